// File: rtl/vram_read_arbiter.sv
// vram_read_arbiter: shares the single VRAM read-burst port between the
// display row prefetch (strict priority) and the renderer read port, and
// routes returning read words to the current burst owner.
//
// Ports:
//   i_master_clk, i_reset              clock, synchronous active-high reset
//   i_display_start/_address           display row prefetch request (strobe)
//   o_display_column/_data/_data_valid display read words with word index
//   o_display_overrun                  start dropped, one already pending
//   i_render_req/_address/_length      renderer burst request (level)
//   o_render_ack/_data/_data_valid     renderer accept pulse and read words
//   o_render_done                      renderer burst complete or aborted
//   o_vram_address/_length/_start      burst request to the VRAM controller
//   i_vram_data/_data_valid            read words from the VRAM controller
//   o_error                            burst aborted on timeout
//
// Optional build macro VRAM_ARB_STATS_EN adds o_stat_disp_bursts,
// o_stat_rend_bursts and o_stat_max_disp_wait.
module vram_read_arbiter #(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned LEN_W    = 10,
    parameter int unsigned DISP_LEN = 512,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic              i_master_clk,
    input  logic              i_reset,
    input  logic              i_display_start,
    input  logic [ADDR_W-1:0] i_display_address,
    output logic [8:0]        o_display_column,
    output logic [23:0]       o_display_data,
    output logic              o_display_data_valid,
    output logic              o_display_overrun,
    input  logic              i_render_req,
    input  logic [ADDR_W-1:0] i_render_address,
    input  logic [LEN_W-1:0]  i_render_length,
    output logic              o_render_ack,
    output logic [23:0]       o_render_data,
    output logic              o_render_data_valid,
    output logic              o_render_done,
    output logic [ADDR_W-1:0] o_vram_address,
    output logic [LEN_W-1:0]  o_vram_length,
    output logic              o_vram_start,
    input  logic [23:0]       i_vram_data,
    input  logic              i_vram_data_valid,
    output logic              o_error
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       o_stat_disp_bursts,
    output logic [15:0]       o_stat_rend_bursts,
    output logic [15:0]       o_stat_max_disp_wait
`endif
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_D_ISSUE = 3'd1;
    localparam logic [2:0] S_D_WAIT  = 3'd2;
    localparam logic [2:0] S_R_ISSUE = 3'd3;
    localparam logic [2:0] S_R_WAIT  = 3'd4;

    logic [2:0]        state, state_n;
    logic              pend, pend_n;
    logic [ADDR_W-1:0] pend_addr, pend_addr_n;
    logic [LEN_W-1:0]  cnt, cnt_n, cnt_inc;
    logic [LEN_W-1:0]  burst_len, burst_len_n;
    logic [TO_W-1:0]   tcnt, tcnt_n;

    logic [8:0]        disp_col_n;
    logic [23:0]       disp_data_n;
    logic              disp_valid_n;
    logic              overrun_n;
    logic              render_ack_n;
    logic [23:0]       rend_data_n;
    logic              rend_valid_n;
    logic              render_done_n;
    logic [ADDR_W-1:0] vram_address_n;
    logic [LEN_W-1:0]  vram_length_n;
    logic              vram_start_n;
    logic              error_n;

    assign cnt_inc = cnt + LEN_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_n        = state;
        pend_n         = pend;
        pend_addr_n    = pend_addr;
        cnt_n          = cnt;
        burst_len_n    = burst_len;
        tcnt_n         = tcnt;
        disp_col_n     = o_display_column;
        disp_data_n    = o_display_data;
        disp_valid_n   = 1'b0;
        overrun_n      = 1'b0;
        render_ack_n   = 1'b0;
        rend_data_n    = o_render_data;
        rend_valid_n   = 1'b0;
        render_done_n  = 1'b0;
        vram_address_n = o_vram_address;
        vram_length_n  = o_vram_length;
        vram_start_n   = 1'b0;
        error_n        = 1'b0;

        // Only one display row can wait; a second start keeps the first address.
        if (i_display_start) begin
            if (pend) begin
                overrun_n = 1'b1;
            end else begin
                pend_n      = 1'b1;
                pend_addr_n = i_display_address;
            end
        end

        case (state)
            S_IDLE: begin
                if (pend) begin
                    state_n        = S_D_ISSUE;
                    pend_n         = 1'b0;
                    vram_address_n = pend_addr;
                    vram_length_n  = LEN_W'(DISP_LEN);
                    vram_start_n   = 1'b1;
                    burst_len_n    = LEN_W'(DISP_LEN);
                    cnt_n          = '0;
                    tcnt_n         = '0;
                end else if (i_render_req && !i_display_start) begin
                    // A start in this same cycle becomes pending and wins next cycle.
                    state_n      = S_R_ISSUE;
                    render_ack_n = 1'b1;
                    burst_len_n  = i_render_length;
                    cnt_n        = '0;
                    tcnt_n       = '0;
                    if (i_render_length != '0) begin
                        vram_address_n = i_render_address;
                        vram_length_n  = i_render_length;
                        vram_start_n   = 1'b1;
                    end
                end
            end
            S_D_ISSUE: state_n = S_D_WAIT;
            S_R_ISSUE: begin
                if (burst_len == '0) begin
                    state_n       = S_IDLE;
                    render_done_n = 1'b1;
                end else begin
                    state_n = S_R_WAIT;
                end
            end
            S_D_WAIT, S_R_WAIT: begin
                if (i_vram_data_valid) begin
                    tcnt_n = '0;
                    cnt_n  = cnt_inc;
                    if (state == S_D_WAIT) begin
                        disp_valid_n = 1'b1;
                        disp_data_n  = i_vram_data;
                        disp_col_n   = cnt[8:0];
                    end else begin
                        rend_valid_n = 1'b1;
                        rend_data_n  = i_vram_data;
                    end
                    if (cnt_inc == burst_len) begin
                        state_n       = S_IDLE;
                        render_done_n = (state == S_R_WAIT);
                    end
                end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                    // Controller went silent: abandon the burst, drop the rest.
                    state_n       = S_IDLE;
                    error_n       = 1'b1;
                    render_done_n = (state == S_R_WAIT);
                end else begin
                    tcnt_n = tcnt + TO_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge i_master_clk) begin
        if (i_reset) begin
            state                <= S_IDLE;
            pend                 <= 1'b0;
            pend_addr            <= '0;
            cnt                  <= '0;
            burst_len            <= '0;
            tcnt                 <= '0;
            o_display_column     <= '0;
            o_display_data       <= '0;
            o_display_data_valid <= 1'b0;
            o_display_overrun    <= 1'b0;
            o_render_ack         <= 1'b0;
            o_render_data        <= '0;
            o_render_data_valid  <= 1'b0;
            o_render_done        <= 1'b0;
            o_vram_address       <= '0;
            o_vram_length        <= '0;
            o_vram_start         <= 1'b0;
            o_error              <= 1'b0;
        end else begin
            state                <= state_n;
            pend                 <= pend_n;
            pend_addr            <= pend_addr_n;
            cnt                  <= cnt_n;
            burst_len            <= burst_len_n;
            tcnt                 <= tcnt_n;
            o_display_column     <= disp_col_n;
            o_display_data       <= disp_data_n;
            o_display_data_valid <= disp_valid_n;
            o_display_overrun    <= overrun_n;
            o_render_ack         <= render_ack_n;
            o_render_data        <= rend_data_n;
            o_render_data_valid  <= rend_valid_n;
            o_render_done        <= render_done_n;
            o_vram_address       <= vram_address_n;
            o_vram_length        <= vram_length_n;
            o_vram_start         <= vram_start_n;
            o_error              <= error_n;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic        disp_go;
    logic        rend_go;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cand;

    assign disp_go   = (state == S_IDLE) && pend;
    assign rend_go   = (state == S_IDLE) && !pend && !i_display_start && i_render_req
                       && (i_render_length != '0);
    assign wait_cand = (wait_cnt == 16'hffff) ? 16'hffff : wait_cnt + 16'd1;

    // Burst counters and worst display start-to-issue wait
    always_ff @(posedge i_master_clk) begin
        if (i_reset) begin
            o_stat_disp_bursts   <= '0;
            o_stat_rend_bursts   <= '0;
            o_stat_max_disp_wait <= '0;
            wait_cnt             <= '0;
        end else begin
            if (disp_go) begin
                o_stat_disp_bursts <= o_stat_disp_bursts + 16'd1;
                if (wait_cand > o_stat_max_disp_wait) begin
                    o_stat_max_disp_wait <= wait_cand;
                end
            end
            if (rend_go) begin
                o_stat_rend_bursts <= o_stat_rend_bursts + 16'd1;
            end
            if (i_display_start && !pend) begin
                wait_cnt <= 16'd1;
            end else if (pend) begin
                wait_cnt <= wait_cand;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vram_read_arbiter.sv
// Randomized self-checking bench for vram_read_arbiter. The bench also plays
// the VRAM controller: it answers every o_vram_start with random data words
// and random gaps, optionally truncating a burst or injecting stray words.
module tb_vram_read_arbiter;
    localparam int unsigned ADDR_W   = 20;
    localparam int unsigned LEN_W    = 10;
    localparam int unsigned DISP_LEN = 512;
    localparam int unsigned TIMEOUT  = 1023;

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_start;
    logic [ADDR_W-1:0] disp_addr;
    logic [8:0]        disp_col;
    logic [23:0]       disp_data;
    logic              disp_valid;
    logic              disp_ovr;
    logic              rreq;
    logic [ADDR_W-1:0] raddr;
    logic [LEN_W-1:0]  rlen;
    logic              rack;
    logic [23:0]       rdata;
    logic              rvalid;
    logic              rdone;
    logic [ADDR_W-1:0] vaddr;
    logic [LEN_W-1:0]  vlen;
    logic              vstart;
    logic [23:0]       vdata;
    logic              vvalid;
    logic              err;

    vram_read_arbiter #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DISP_LEN(DISP_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_master_clk        (clk),
        .i_reset             (rst),
        .i_display_start     (disp_start),
        .i_display_address   (disp_addr),
        .o_display_column    (disp_col),
        .o_display_data      (disp_data),
        .o_display_data_valid(disp_valid),
        .o_display_overrun   (disp_ovr),
        .i_render_req        (rreq),
        .i_render_address    (raddr),
        .i_render_length     (rlen),
        .o_render_ack        (rack),
        .o_render_data       (rdata),
        .o_render_data_valid (rvalid),
        .o_render_done       (rdone),
        .o_vram_address      (vaddr),
        .o_vram_length       (vlen),
        .o_vram_start        (vstart),
        .i_vram_data         (vdata),
        .i_vram_data_valid   (vvalid),
        .o_error             (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations
    logic [63:0] bq_addr[$];
    logic [63:0] bq_len[$];
    logic [63:0] bq_cyc[$];
    int          dq_col[$];
    logic [23:0] dq_data[$];
    logic [23:0] rq_data[$];
    int ack_n, done_n, ovr_n, err_n;
    int ack_cyc, done_cyc, err_cyc, last_disp_cyc, last_rend_cyc;

    // Responder state
    int          resp_q[$];
    int          resp_left  = 0;
    int          resp_trunc = -1;
    int          stray_left = 0;
    logic [23:0] sent_q[$];

    int ack_base = 0;
    int sc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (vstart) begin
            bq_addr.push_back(64'(vaddr));
            bq_len.push_back(64'(vlen));
            bq_cyc.push_back(64'(cyc));
            resp_q.push_back(int'(vlen));
        end
        if (disp_valid) begin
            dq_col.push_back(int'(disp_col));
            dq_data.push_back(disp_data);
            last_disp_cyc = cyc;
        end
        if (rvalid) begin
            rq_data.push_back(rdata);
            last_rend_cyc = cyc;
        end
        if (rack)     begin ack_n++;  ack_cyc  = cyc; end
        if (rdone)    begin done_n++; done_cyc = cyc; end
        if (disp_ovr) ovr_n++;
        if (err)      begin err_n++;  err_cyc  = cyc; end
    end

    // VRAM controller model
    initial begin : responder
        int l;
        vvalid = 1'b0;
        vdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            vvalid = 1'b0;
            if (resp_left == 0 && resp_q.size() > 0) begin
                l = resp_q.pop_front();
                resp_left = (resp_trunc >= 0 && resp_trunc < l) ? resp_trunc : l;
            end else if (resp_left > 0) begin
                if ($urandom_range(0, 2) != 0) begin
                    vvalid = 1'b1;
                    vdata  = 24'($urandom);
                    sent_q.push_back(vdata);
                    resp_left--;
                end
            end else if (stray_left > 0) begin
                vvalid = 1'b1;
                vdata  = 24'($urandom);
                stray_left--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rreq && ack_n != ack_base) rreq = 1'b0;
    endtask

    function automatic int obs(input int which);
        case (which)
            0:       return bq_addr.size();
            1:       return dq_data.size();
            2:       return rq_data.size();
            3:       return ack_n;
            4:       return done_n;
            default: return err_n;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int budget, input string tag);
        int n = 0;
        while (obs(which) < target && n < budget) begin
            tick();
            n++;
        end
        if (obs(which) < target) check_eq({tag, "_timeout"}, 64'(obs(which)), 64'(target));
    endtask

    function automatic logic [63:0] bq_field(input int i, input int f);
        if (i >= bq_addr.size()) return '1;
        case (f)
            0:       return bq_addr[i];
            1:       return bq_len[i];
            default: return bq_cyc[i];
        endcase
    endfunction

    function automatic int disp_mism(input int n);
        int m = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= dq_data.size() || i >= sent_q.size()) m++;
            else if (dq_col[i] != (i % 512) || dq_data[i] != sent_q[i]) m++;
        end
        return m;
    endfunction

    function automatic int rend_mism(input int off, input int n);
        int m = 0;
        for (int j = 0; j < n; j++) begin
            if (j >= rq_data.size() || off + j >= sent_q.size()) m++;
            else if (rq_data[j] != sent_q[off + j]) m++;
        end
        return m;
    endfunction

    task automatic clear_obs();
        bq_addr.delete(); bq_len.delete(); bq_cyc.delete();
        dq_col.delete(); dq_data.delete(); rq_data.delete(); sent_q.delete();
        ack_n = 0; done_n = 0; ovr_n = 0; err_n = 0;
        ack_cyc = 0; done_cyc = 0; err_cyc = 0; last_disp_cyc = 0; last_rend_cyc = 0;
    endtask

    task automatic disp_pulse(input logic [ADDR_W-1:0] a);
        disp_start = 1'b1;
        disp_addr  = a;
        sc = cyc;
        tick();
        disp_start = 1'b0;
    endtask

    task automatic render_req(input logic [ADDR_W-1:0] a, input int l);
        rreq     = 1'b1;
        raddr    = a;
        rlen     = LEN_W'(l);
        ack_base = ack_n;
    endtask

    function automatic logic any_out();
        return |{disp_col, disp_data, disp_valid, disp_ovr, rack, rdata, rvalid,
                 rdone, vaddr, vlen, vstart, err};
    endfunction

    // One display row
    task automatic scen_display(input logic [ADDR_W-1:0] a);
        clear_obs();
        disp_pulse(a);
        wait_for(1, 512, 4000, "s1_words");
        repeat (4) tick();
        check_eq("s1_bursts", 64'(bq_addr.size()), 1);
        check_eq("s1_latency", bq_field(0, 2) - 64'(sc), 2);
        check_eq("s1_addr", bq_field(0, 0), 64'(a));
        check_eq("s1_len", bq_field(0, 1), 512);
        check_eq("s1_nwords", 64'(dq_data.size()), 512);
        check_eq("s1_words_bad", 64'(disp_mism(512)), 0);
        check_eq("s1_render_idle", 64'(rq_data.size() + ack_n), 0);
    endtask

    // Renderer request arriving during a display burst waits for it
    task automatic scen_rend_during(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] ra,
                                    input int rl);
        clear_obs();
        disp_pulse(a);
        wait_for(0, 1, 20, "s2_dstart");
        repeat ($urandom_range(5, 200)) tick();
        render_req(ra, rl);
        wait_for(4, 1, 4000, "s2_done");
        repeat (3) tick();
        check_eq("s2_acks", 64'(ack_n), 1);
        check_eq("s2_ack_after_disp", 64'(ack_cyc > last_disp_cyc), 1);
        check_eq("s2_disp_nwords", 64'(dq_data.size()), 512);
        check_eq("s2_raddr", bq_field(1, 0), 64'(ra));
        check_eq("s2_rlen", bq_field(1, 1), 64'(rl));
        check_eq("s2_rwords", 64'(rq_data.size()), 64'(rl));
        check_eq("s2_rwords_bad", 64'(rend_mism(512, rl)), 0);
        check_eq("s2_done_n", 64'(done_n), 1);
        check_eq("s2_done_time", 64'(done_cyc >= last_rend_cyc), 1);
    endtask

    // Display start and render request in the same idle cycle
    task automatic scen_same_cycle(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] ra,
                                   input int rl);
        clear_obs();
        render_req(ra, rl);
        disp_pulse(a);
        wait_for(4, 1, 4000, "s3_done");
        repeat (3) tick();
        check_eq("s3_latency", bq_field(0, 2) - 64'(sc), 2);
        check_eq("s3_first_len", bq_field(0, 1), 512);
        check_eq("s3_first_addr", bq_field(0, 0), 64'(a));
        check_eq("s3_second_addr", bq_field(1, 0), 64'(ra));
        check_eq("s3_ack_after_disp", 64'(ack_cyc > last_disp_cyc), 1);
        check_eq("s3_words_bad", 64'(disp_mism(512) + rend_mism(512, rl)), 0);
    endtask

    // Two starts during a display burst: one overrun, first address kept
    task automatic scen_overrun(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                                input logic [ADDR_W-1:0] c);
        clear_obs();
        disp_pulse(a);
        wait_for(1, $urandom_range(10, 400), 3000, "s4_mid");
        disp_pulse(b);
        repeat ($urandom_range(0, 4)) tick();
        disp_pulse(c);
        wait_for(1, 1024, 5000, "s4_words");
        repeat (20) tick();
        check_eq("s4_overruns", 64'(ovr_n), 1);
        check_eq("s4_bursts", 64'(bq_addr.size()), 2);
        check_eq("s4_addr2", bq_field(1, 0), 64'(b));
        check_eq("s4_words_bad", 64'(disp_mism(1024)), 0);
    endtask

    // Controller stalls mid-burst: timeout abort, strays ignored, next served
    task automatic scen_timeout(input logic [ADDR_W-1:0] a, input int trunc,
                                input logic [ADDR_W-1:0] ra, input int rl);
        clear_obs();
        resp_trunc = trunc;
        disp_pulse(a);
        wait_for(5, 1, trunc * 4 + int'(TIMEOUT) + 100, "s5_err");
        repeat (2) tick();
        resp_trunc = -1;
        check_eq("s5_err_n", 64'(err_n), 1);
        check_eq("s5_err_gap", 64'(err_cyc - last_disp_cyc), 64'(TIMEOUT));
        check_eq("s5_words_bad", 64'(disp_mism(trunc)), 0);
        stray_left = 6;
        repeat (20) tick();
        check_eq("s5_stray_disp", 64'(dq_data.size()), 64'(trunc));
        check_eq("s5_stray_rend", 64'(rq_data.size()), 0);
        render_req(ra, rl);
        wait_for(4, 1, 500, "s5_rdone");
        repeat (3) tick();
        check_eq("s5_raddr", bq_field(1, 0), 64'(ra));
        check_eq("s5_rwords_bad", 64'(rend_mism(trunc, rl)), 0);
        check_eq("s5_rwords", 64'(rq_data.size()), 64'(rl));
    endtask

    // Zero-length render request, then reset in the middle of a render burst
    task automatic scen_len0_reset(input logic [ADDR_W-1:0] ra, input int rl);
        clear_obs();
        render_req(ra, 0);
        wait_for(4, 1, 50, "s6_done0");
        repeat (3) tick();
        check_eq("s6_no_vram", 64'(bq_addr.size()), 0);
        check_eq("s6_done_gap", 64'(done_cyc - ack_cyc), 1);
        resp_trunc = 4;
        render_req(ra, rl);
        wait_for(2, 4, 200, "s6_part");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_eq("s6_rst_outs", 64'(any_out()), 0);
        tick();
        rst = 1'b0;
        resp_trunc = -1;
        stray_left = 6;
        repeat (20) tick();
        check_eq("s6_stray_rend", 64'(rq_data.size()), 4);
        check_eq("s6_stray_err", 64'(err_n), 0);
        render_req(ra + 20'h40, 3);
        wait_for(4, 2, 200, "s6_after");
        repeat (3) tick();
        check_eq("s6_after_words", 64'(rq_data.size()), 7);
        check_eq("s6_words_bad", 64'(rend_mism(0, 7)), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst        = 1'b1;
        disp_start = 1'b0;
        disp_addr  = '0;
        rreq       = 1'b0;
        raddr      = '0;
        rlen       = '0;
        clear_obs();
        repeat (3) tick();
        check_eq("reset_outs", 64'(any_out()), 0);
        rst = 1'b0;
        tick();
        check_eq("post_reset_outs", 64'(any_out()), 0);

        for (int it = 0; it < 3; it++) begin
            scen_display((it == 0) ? 20'h80000 : 20'($urandom));
            scen_rend_during(20'($urandom), (it == 0) ? 20'h00100 : 20'($urandom),
                             (it == 0) ? 8 : $urandom_range(1, 16));
            scen_same_cycle(20'($urandom), 20'($urandom), $urandom_range(1, 16));
            scen_overrun(20'($urandom), 20'($urandom), 20'($urandom));
            scen_timeout(20'($urandom), (it == 0) ? 100 : $urandom_range(20, 200),
                         20'($urandom), $urandom_range(1, 16));
            scen_len0_reset(20'($urandom), $urandom_range(8, 30));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
